alu_exec_stage: RTL and testbench

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/PkgAlu.sv | 41 ++++
 rtl/Adder.sv | 12 +
 rtl/ArithmeticShiftRight32.sv | 11 +
 rtl/Compare.sv | 20 ++
 rtl/LogicalShiftLeft32.sv | 11 +
 rtl/LogicalShiftRight32.sv | 11 +
 rtl/Subtractor.sv | 12 +
 rtl/alu_result_mux.sv | 50 +++++
 rtl/alu_exec_stage.sv | 137 +++++++++++++
 tb/tb_alu_exec_stage.sv | 233 +++++++++++++++++++++++
 10 files changed

// File: rtl/PkgAlu.sv
// PkgAlu: shared definitions for the ALU execute stage.
//   AluOp  - 4-bit operation code. Codes 13..15 are undefined and flagged illegal.
//   s1_t   - payload held in the operand stage (op, a, b).
//   s2_t   - payload held in the result stage (result, zero, illegal).
// The tag is kept outside the structs so that its width can follow the
// TAG_WIDTH parameter of the stage.
package PkgAlu;

  localparam int ALU_DW = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLTU = 4'd2,
    ALU_SLTS = 4'd3,
    ALU_SGTU = 4'd4,
    ALU_SGTS = 4'd5,
    ALU_AND  = 4'd6,
    ALU_OR   = 4'd7,
    ALU_XOR  = 4'd8,
    ALU_NOR  = 4'd9,
    ALU_LSL  = 4'd10,
    ALU_LSR  = 4'd11,
    ALU_ASR  = 4'd12
  } AluOp;

  // The op field is a raw code rather than AluOp so undefined codes survive
  // into the result mux, where they are detected.
  typedef struct packed {
    logic [3:0]        op;
    logic [ALU_DW-1:0] a;
    logic [ALU_DW-1:0] b;
  } s1_t;

  typedef struct packed {
    logic [ALU_DW-1:0] result;
    logic              zero;
    logic              illegal;
  } s2_t;

endpackage

// File: rtl/Adder.sv
// Adder: combinational wrap-around adder.
//   a, b - operands
//   sum  - a + b modulo 2^WIDTH (carry discarded)
module Adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/ArithmeticShiftRight32.sv
// ArithmeticShiftRight32: 32-bit right shift, sign fill.
//   a     - value to shift (two's complement)
//   shamt - shift amount 0..31
//   y     - a >>> shamt
module ArithmeticShiftRight32 (
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  output logic [31:0] y
);
  assign y = $unsigned($signed(a) >>> shamt);
endmodule

// File: rtl/Compare.sv
// Compare: unsigned and signed magnitude comparison of two operands.
//   a, b     - operands
//   ltu, lts - a < b (unsigned / signed)
//   gtu, gts - a > b (unsigned / signed)
// Equal operands make all four outputs 0.
module Compare #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ltu,
  output logic             lts,
  output logic             gtu,
  output logic             gts
);
  assign ltu = a < b;
  assign gtu = a > b;
  assign lts = $signed(a) < $signed(b);
  assign gts = $signed(a) > $signed(b);
endmodule

// File: rtl/LogicalShiftLeft32.sv
// LogicalShiftLeft32: 32-bit left shift, zero fill.
//   a     - value to shift
//   shamt - shift amount 0..31
//   y     - a << shamt
module LogicalShiftLeft32 (
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  output logic [31:0] y
);
  assign y = a << shamt;
endmodule

// File: rtl/LogicalShiftRight32.sv
// LogicalShiftRight32: 32-bit right shift, zero fill.
//   a     - value to shift
//   shamt - shift amount 0..31
//   y     - a >> shamt
module LogicalShiftRight32 (
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  output logic [31:0] y
);
  assign y = a >> shamt;
endmodule

// File: rtl/Subtractor.sv
// Subtractor: combinational wrap-around subtractor.
//   a, b - operands
//   diff - a - b modulo 2^WIDTH (borrow discarded)
module Subtractor #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff
);
  assign diff = a - b;
endmodule

// File: rtl/alu_result_mux.sv
// alu_result_mux: selects the ALU result from the arithmetic unit outputs.
// Purely combinational.
//   op                 - raw 4-bit operation code
//   a, b               - operands (bitwise ops are formed here)
//   sum, diff          - adder / subtractor outputs
//   ltu, lts, gtu, gts - comparator outputs
//   shl, shr, sra      - shifter outputs
//   result             - selected result, 0 for an undefined code
//   illegal            - op is not a defined AluOp code
module alu_result_mux
  import PkgAlu::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] sum,
  input  logic [DATA_WIDTH-1:0] diff,
  input  logic                  ltu,
  input  logic                  lts,
  input  logic                  gtu,
  input  logic                  gts,
  input  logic [DATA_WIDTH-1:0] shl,
  input  logic [DATA_WIDTH-1:0] shr,
  input  logic [DATA_WIDTH-1:0] sra,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  illegal
);
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      ALU_ADD:  result = sum;
      ALU_SUB:  result = diff;
      ALU_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, ltu};
      ALU_SLTS: result = {{(DATA_WIDTH-1){1'b0}}, lts};
      ALU_SGTU: result = {{(DATA_WIDTH-1){1'b0}}, gtu};
      ALU_SGTS: result = {{(DATA_WIDTH-1){1'b0}}, gts};
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_LSL:  result = shl;
      ALU_LSR:  result = shr;
      ALU_ASR:  result = sra;
      default:  illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: two-stage pipelined ALU with valid/ready handshakes.
//   S1 registers the accepted op/operands/tag; S2 registers result/flags/tag.
//   Latency is 2 cycles from accept to out_valid, one op per cycle sustained.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   flush            - synchronous kill of everything in flight
//   in_valid/in_ready, in_op, in_a, in_b, in_tag        - operation input
//   out_valid/out_ready, out_result, out_tag, out_zero,
//   out_illegal      - result output (all zero while out_valid=0)
module alu_exec_stage
  import PkgAlu::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_zero,
  output logic                  out_illegal
);

  if (DATA_WIDTH != ALU_DW) begin : g_width_check
    $error("alu_exec_stage supports DATA_WIDTH=32 only");
  end

  s1_t                  s1_reg;
  logic [TAG_WIDTH-1:0] s1_tag_reg;
  logic                 s1_valid_reg;
  s2_t                  s2_reg;
  s2_t                  s2_next;
  logic [TAG_WIDTH-1:0] s2_tag_reg;
  logic                 s2_valid_reg;

  logic s2_adv;
  logic s1_adv;
  logic accept;

  // Handshake: in_ready never looks at in_valid, so no comb loop upstream.
  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_adv   = s1_valid_reg && s2_adv;
  assign in_ready = !s1_valid_reg || s1_adv;
  assign accept   = in_valid && in_ready;

  // Arithmetic units between S1 and S2.
  logic [DATA_WIDTH-1:0] sum, diff, shl, shr, sra, mux_result;
  logic                  ltu, lts, gtu, gts, mux_illegal;

  Adder #(.WIDTH(DATA_WIDTH)) u_add (
    .a(s1_reg.a), .b(s1_reg.b), .sum(sum)
  );

  Subtractor #(.WIDTH(DATA_WIDTH)) u_sub (
    .a(s1_reg.a), .b(s1_reg.b), .diff(diff)
  );

  Compare #(.WIDTH(DATA_WIDTH)) u_cmp (
    .a(s1_reg.a), .b(s1_reg.b),
    .ltu(ltu), .lts(lts), .gtu(gtu), .gts(gts)
  );

  // Shift amount is b[4:0]; the upper bits of b are ignored.
  LogicalShiftLeft32 u_lsl (
    .a(s1_reg.a), .shamt(s1_reg.b[4:0]), .y(shl)
  );

  LogicalShiftRight32 u_lsr (
    .a(s1_reg.a), .shamt(s1_reg.b[4:0]), .y(shr)
  );

  ArithmeticShiftRight32 u_asr (
    .a(s1_reg.a), .shamt(s1_reg.b[4:0]), .y(sra)
  );

  alu_result_mux #(.DATA_WIDTH(DATA_WIDTH)) u_mux (
    .op(s1_reg.op), .a(s1_reg.a), .b(s1_reg.b),
    .sum(sum), .diff(diff),
    .ltu(ltu), .lts(lts), .gtu(gtu), .gts(gts),
    .shl(shl), .shr(shr), .sra(sra),
    .result(mux_result), .illegal(mux_illegal)
  );

  always_comb begin
    s2_next.result  = mux_result;
    s2_next.zero    = (mux_result == '0);
    s2_next.illegal = mux_illegal;
  end

  // Valid bits: the only reset state. Flush wins over any transfer, so an
  // input accepted in the flush cycle is dropped and a result handed out in
  // that cycle is simply not replaced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else if (flush) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      if (in_ready) s1_valid_reg <= in_valid;
      if (s2_adv)   s2_valid_reg <= s1_valid_reg;
    end
  end

  // Data registers carry no reset; their contents are only observed through
  // the valid bits.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_reg.op  <= in_op;
      s1_reg.a   <= in_a;
      s1_reg.b   <= in_b;
      s1_tag_reg <= in_tag;
    end
    if (s1_adv) begin
      s2_reg     <= s2_next;
      s2_tag_reg <= s1_tag_reg;
    end
  end

  // Outputs gated so they read zero whenever nothing valid is held.
  assign out_valid   = s2_valid_reg;
  assign out_result  = s2_valid_reg ? s2_reg.result : '0;
  assign out_tag     = s2_valid_reg ? s2_tag_reg : '0;
  assign out_zero    = s2_valid_reg & s2_reg.zero;
  assign out_illegal = s2_valid_reg & s2_reg.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed-vector bench for alu_exec_stage.
// Expected results are hand-computed and queued at accept time; a monitor on
// the falling edge compares every held or delivered result with the queue head.
module tb_alu_exec_stage;
  import PkgAlu::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_zero;
  logic        out_illegal;

  always #5 clk = ~clk;

  alu_exec_stage #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_zero(out_zero), .out_illegal(out_illegal)
  );

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  tag;
    logic        zero;
    logic        illegal;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   total_waits = 0;

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Offer one op (called just after a rising edge), wait for acceptance and
  // queue its expected result.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] res, input logic ill);
    int waits = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(negedge clk);
    while (!in_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    total_waits += waits;
    if (!in_ready) begin
      check_val("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_q.push_back('{result: res, tag: tag, zero: (res == 32'd0), illegal: ill});
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(posedge clk);
    end
    check_val("drain", 32'(exp_q.size()), 32'd0);
    #1;
  endtask

  // Scoreboard monitor: one line per delivered result.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        mon_e = exp_q[0];
        check_val("result",  out_result,        mon_e.result);
        check_val("tag",     32'(out_tag),      32'(mon_e.tag));
        check_val("zero",    32'(out_zero),     32'(mon_e.zero));
        check_val("illegal", 32'(out_illegal),  32'(mon_e.illegal));
        if (out_ready) begin
          void'(exp_q.pop_front());
          $display("xfer tag=%0d result=0x%08h zero=%0b illegal=%0b",
                   out_tag, out_result, out_zero, out_illegal);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 4'd0; in_a = 32'd0; in_b = 32'd0; in_tag = 5'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_out_valid",   32'(out_valid),   32'd0);
    check_val("rst_in_ready",    32'(in_ready),    32'd1);
    check_val("rst_out_result",  out_result,       32'd0);
    check_val("rst_out_tag",     32'(out_tag),     32'd0);
    check_val("rst_out_zero",    32'(out_zero),    32'd0);
    check_val("rst_out_illegal", 32'(out_illegal), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // ADD wrap with latency check
    issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 5'd3, 32'd0, 1'b0);
    @(negedge clk);
    check_val("lat1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_val("lat2_valid",  32'(out_valid), 32'd1);
    check_val("lat2_result", out_result,     32'd0);
    check_val("lat2_zero",   32'(out_zero),  32'd1);
    check_val("lat2_tag",    32'(out_tag),   32'd3);
    @(posedge clk); #1;

    // Back-to-back directed vectors at full rate
    total_waits = 0;
    issue(ALU_SLTS, 32'hFFFF_FFFE, 32'd1, 5'd4,  32'd1, 1'b0);
    issue(ALU_SLTU, 32'hFFFF_FFFE, 32'd1, 5'd5,  32'd0, 1'b0);
    issue(ALU_SGTU, 32'hFFFF_FFFE, 32'd1, 5'd6,  32'd1, 1'b0);
    issue(ALU_SGTS, 32'hFFFF_FFFE, 32'd1, 5'd7,  32'd0, 1'b0);
    issue(ALU_SGTS, 32'd7, 32'd7, 5'd8,  32'd0, 1'b0);
    issue(ALU_SGTU, 32'd7, 32'd7, 5'd9,  32'd0, 1'b0);
    issue(ALU_SLTS, 32'd7, 32'd7, 5'd10, 32'd0, 1'b0);
    issue(ALU_SLTU, 32'd7, 32'd7, 5'd11, 32'd0, 1'b0);
    issue(ALU_ASR, 32'h8000_0000, 32'h0000_0024, 5'd12, 32'hF800_0000, 1'b0);
    issue(ALU_LSR, 32'h8000_0000, 32'h0000_0024, 5'd13, 32'h0800_0000, 1'b0);
    issue(ALU_LSL, 32'h8000_0001, 32'h0000_0021, 5'd14, 32'h0000_0002, 1'b0);
    issue(ALU_SUB, 32'd5, 32'd7, 5'd15, 32'hFFFF_FFFE, 1'b0);
    issue(ALU_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd16, 32'h00F0_000F, 1'b0);
    issue(ALU_OR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd17, 32'hFFF0_0FFF, 1'b0);
    issue(ALU_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd18, 32'hFF00_0FF0, 1'b0);
    issue(ALU_NOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd19, 32'h000F_F000, 1'b0);
    check_val("throughput_waits", 32'(total_waits), 32'd0);
    wait_drain();

    // Backpressure: two accepted, then in_ready drops and output holds
    out_ready = 1'b0;
    issue(ALU_ADD, 32'd1,  32'd1, 5'd1, 32'd2,  1'b0);
    issue(ALU_SUB, 32'd10, 32'd3, 5'd2, 32'd7,  1'b0);
    repeat (4) begin
      @(negedge clk);
      check_val("stall_in_ready",  32'(in_ready),  32'd0);
      check_val("stall_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(ALU_XOR, 32'hF, 32'h3, 5'd3, 32'hC,  1'b0);
    issue(ALU_LSL, 32'h1, 32'h4, 5'd4, 32'h10, 1'b0);
    wait_drain();

    // Undefined op followed by a normal op
    issue(4'd14,   32'd9, 32'd9, 5'd20, 32'd0, 1'b1);
    issue(ALU_ADD, 32'd2, 32'd3, 5'd21, 32'd5, 1'b0);
    wait_drain();

    // Flush with two ops in flight; S2 consumed in the flush cycle, the
    // concurrent input is dropped.
    out_ready = 1'b0;
    issue(ALU_ADD, 32'd100, 32'd1, 5'd22, 32'd101, 1'b0);
    issue(ALU_ADD, 32'd200, 32'd1, 5'd23, 32'd201, 1'b0);
    flush = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = ALU_ADD; in_a = 32'd55; in_b = 32'd1; in_tag = 5'd24;
    @(negedge clk);
    check_val("flush_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check_val("post_flush_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    issue(ALU_ADD, 32'd7, 32'd8, 5'd9, 32'd15, 1'b0);
    wait_drain();

    // Reset pulse mid-stream
    issue(ALU_ADD, 32'd1, 32'd2, 5'd10, 32'd3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_val("midrst_out_valid", 32'(out_valid), 32'd0);
    check_val("midrst_in_ready",  32'(in_ready),  32'd1);
    check_val("midrst_result",    out_result,     32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    issue(ALU_SUB, 32'd9, 32'd4, 5'd12, 32'd5, 1'b0);
    @(negedge clk);
    check_val("rst_lat1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_val("rst_lat2_valid",  32'(out_valid), 32'd1);
    check_val("rst_lat2_result", out_result,     32'd5);
    check_val("rst_lat2_tag",    32'(out_tag),   32'd12);
    @(posedge clk); #1;
    wait_drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
